arp_header_parser: RTL

Passive AXI4-Stream tap placed directly upstream of the ARP-defence CAM lookup stage. It observes accepted beats on the 256-bit ingress stream and recognises Ethernet/IPv4 ARP frames. It extracts the opcode, sender protocol address and target protocol address, queues them in a 2-entry holding FIFO, and drives the lookup stage's `lookup_req`/`dst_IP`/`src_IP`/`opcode` inputs. Each request is held until `lookup_done` returns; a request that is not answered in time is retried.

---
 rtl/arp_header_parser.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/arp_header_parser.sv
// Passive AXI4-Stream tap: recognises Ethernet/IPv4 ARP frames, queues {oper, spa, tpa}
// in a 2-entry FIFO and drives CAM lookup requests, retrying when no answer arrives in time.
module arp_header_parser #(
  parameter int unsigned TIMEOUT             = 32,
  parameter int unsigned C_S_AXIS_DATA_WIDTH = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  input  logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic                             lookup_req,
  output logic [47:0]                      dst_IP,
  output logic [47:0]                      src_IP,
  output logic [15:0]                      opcode,
  input  logic                             lookup_done,
  output logic [31:0]                      arp_seen_count,
  output logic [15:0]                      arp_drop_count
);

  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {P_SOP, P_BEAT1, P_EOP} parse_state_t;
  typedef enum logic       {L_IDLE, L_WAIT}        lookup_state_t;

  parse_state_t  r_pstate;
  logic          r_b0_ok;
  logic [15:0]   r_oper;
  logic [31:0]   r_spa;

  logic [79:0]   r_fifo [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;

  lookup_state_t r_lstate;
  logic [7:0]    r_cnt;
  logic          r_req;
  logic [47:0]   r_dst;
  logic [47:0]   r_src;
  logic [15:0]   r_opcode;
  logic [31:0]   r_seen;
  logic [15:0]   r_drop;

  logic          w_accept;
  logic          w_b0_ok;
  logic          w_b1_ok;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_en;
  logic          w_drop;
  logic [79:0]   w_entry;
  logic [79:0]   w_head;
  logic          w_unused;

  assign w_accept = s_axis_tvalid & s_axis_tready;

  assign w_b0_ok = (s_axis_tdata[159:144] == 16'h0806) &&
                   (s_axis_tdata[143:128] == 16'h0001) &&
                   (s_axis_tdata[127:112] == 16'h0800) &&
                   (s_axis_tdata[111:104] == 8'd6)     &&
                   (s_axis_tdata[103:96]  == 8'd4);
  assign w_b1_ok = &s_axis_tkeep[31:22];

  // Frame verdict is formed combinationally on the accepted beat 1 so the entry lands next cycle.
  assign w_push  = w_accept && (r_pstate == P_BEAT1) && r_b0_ok && w_b1_ok;
  assign w_entry = {r_oper, r_spa, s_axis_tdata[207:176]};

  assign w_full  = (r_count == 2'd2);
  assign w_empty = (r_count == 2'd0);
  assign w_pop   = (r_lstate == L_WAIT) && lookup_done;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;
  assign w_head  = r_fifo[r_rd_ptr];

  assign w_unused = ^{s_axis_tdata[255:208], s_axis_tdata[175:160],
                      s_axis_tdata[79:32], s_axis_tkeep[21:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pstate <= P_SOP;
      r_b0_ok  <= 1'b0;
      r_oper   <= '0;
      r_spa    <= '0;
    end else if (w_accept) begin
      unique case (r_pstate)
        P_SOP: begin
          r_b0_ok  <= w_b0_ok;
          r_oper   <= s_axis_tdata[95:80];
          r_spa    <= s_axis_tdata[31:0];
          r_pstate <= s_axis_tlast ? P_SOP : P_BEAT1;
        end
        P_BEAT1: r_pstate <= s_axis_tlast ? P_SOP : P_EOP;
        P_EOP:   if (s_axis_tlast) r_pstate <= P_SOP;
        default: r_pstate <= P_SOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_fifo[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)   r_rd_ptr <= ~r_rd_ptr;
      unique case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lstate <= L_IDLE;
      r_cnt    <= '0;
      r_req    <= 1'b0;
      r_dst    <= '0;
      r_src    <= '0;
      r_opcode <= '0;
    end else begin
      r_req <= 1'b0;
      unique case (r_lstate)
        L_IDLE: begin
          if (!w_empty) begin
            r_req    <= 1'b1;
            r_opcode <= w_head[79:64];
            r_src    <= {16'h0, w_head[63:32]};
            r_dst    <= {16'h0, w_head[31:0]};
            r_cnt    <= '0;
            r_lstate <= L_WAIT;
          end
        end
        L_WAIT: begin
          if (lookup_done) begin
            r_lstate <= L_IDLE;
          end else if (r_cnt == LP_TO_LAST) begin
            r_req <= 1'b1;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_lstate <= L_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seen <= '0;
      r_drop <= '0;
    end else begin
      if (w_push) r_seen <= r_seen + 32'd1;
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + 16'd1;
    end
  end

  assign lookup_req     = r_req;
  assign dst_IP         = r_dst;
  assign src_IP         = r_src;
  assign opcode         = r_opcode;
  assign arp_seen_count = r_seen;
  assign arp_drop_count = r_drop;

endmodule
